// File: rtl/cpu.sv
// RV32I single-cycle core: decode and execute are combinational from inst,
// pc and register file commit on the rising clock edge.
module cpu #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [31:0]      inst,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] address,
    output logic             read_n_write
);
    localparam int NREG = 2 ** REG_BITS;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    logic [WIDTH-1:0]    r_pc;
    logic [WIDTH-1:0]    r_regs [NREG];

    logic [6:0]          w_op;
    logic [2:0]          w_f3;
    logic                w_alt;
    logic [REG_BITS-1:0] w_rd;
    logic [REG_BITS-1:0] w_rs1;
    logic [REG_BITS-1:0] w_rs2;
    logic [WIDTH-1:0]    w_a;
    logic [WIDTH-1:0]    w_b;
    logic [WIDTH-1:0]    w_imm_i;
    logic [WIDTH-1:0]    w_imm_s;
    logic [WIDTH-1:0]    w_imm_b;
    logic [WIDTH-1:0]    w_imm_u;
    logic [WIDTH-1:0]    w_imm_j;
    logic [WIDTH-1:0]    w_pc4;
    logic [WIDTH-1:0]    w_opb;
    logic [WIDTH-1:0]    w_jsum;
    logic [4:0]          w_sh;
    logic [WIDTH-1:0]    w_alu;
    logic                w_take;
    logic [WIDTH-1:0]    w_pc_next;
    logic                w_we;
    logic [WIDTH-1:0]    w_wdata;

    assign w_op  = inst[6:0];
    assign w_f3  = inst[14:12];
    assign w_alt = inst[30];
    assign w_rd  = inst[7 +: REG_BITS];
    assign w_rs1 = inst[15 +: REG_BITS];
    assign w_rs2 = inst[20 +: REG_BITS];

    assign w_a = r_regs[w_rs1];
    assign w_b = r_regs[w_rs2];

    assign w_imm_i = WIDTH'($signed(inst[31:20]));
    assign w_imm_s = WIDTH'($signed({inst[31:25], inst[11:7]}));
    assign w_imm_b = WIDTH'($signed({inst[31], inst[7], inst[30:25],
                                     inst[11:8], 1'b0}));
    assign w_imm_u = WIDTH'($signed({inst[31:12], 12'b0}));
    assign w_imm_j = WIDTH'($signed({inst[31], inst[19:12], inst[20],
                                     inst[30:21], 1'b0}));

    assign w_pc4  = r_pc + WIDTH'(4);
    assign w_opb  = (w_op == OP_REG) ? w_b : w_imm_i;
    assign w_sh   = w_opb[4:0];
    assign w_jsum = w_a + w_imm_i;

    // Shared ALU for OP and OP-IMM; inst[30] selects SUB/SRA/SRAI
    always_comb begin
        w_alu = '0;
        unique case (w_f3)
            3'b000: w_alu = (w_op == OP_REG && w_alt) ? w_a - w_opb
                                                     : w_a + w_opb;
            3'b001: w_alu = w_a << w_sh;
            3'b010: w_alu = WIDTH'($signed(w_a) < $signed(w_opb));
            3'b011: w_alu = WIDTH'(w_a < w_opb);
            3'b100: w_alu = w_a ^ w_opb;
            3'b101: w_alu = w_alt ? WIDTH'($signed(w_a) >>> w_sh)
                                  : w_a >> w_sh;
            3'b110: w_alu = w_a | w_opb;
            3'b111: w_alu = w_a & w_opb;
        endcase
    end

    always_comb begin
        w_take = 1'b0;
        unique case (w_f3)
            3'b000:  w_take = (w_a == w_b);
            3'b001:  w_take = (w_a != w_b);
            3'b100:  w_take = ($signed(w_a) < $signed(w_b));
            3'b101:  w_take = ($signed(w_a) >= $signed(w_b));
            3'b110:  w_take = (w_a < w_b);
            3'b111:  w_take = (w_a >= w_b);
            default: w_take = 1'b0;
        endcase
    end

    always_comb begin
        w_pc_next    = w_pc4;
        w_we         = 1'b0;
        w_wdata      = '0;
        address      = '0;
        d            = '0;
        read_n_write = 1'b1;
        unique case (w_op)
            OP_LUI: begin
                w_we    = 1'b1;
                w_wdata = w_imm_u;
            end
            OP_AUIPC: begin
                w_we    = 1'b1;
                w_wdata = r_pc + w_imm_u;
            end
            OP_JAL: begin
                w_we      = 1'b1;
                w_wdata   = w_pc4;
                w_pc_next = r_pc + w_imm_j;
            end
            OP_JALR: begin
                w_we      = 1'b1;
                w_wdata   = w_pc4;
                w_pc_next = {w_jsum[WIDTH-1:1], 1'b0};
            end
            OP_BRANCH: begin
                if (w_take) w_pc_next = r_pc + w_imm_b;
            end
            OP_IMM, OP_REG: begin
                w_we    = 1'b1;
                w_wdata = w_alu;
            end
            OP_STORE: begin
                address      = w_a + w_imm_s;
                d            = w_b;
                read_n_write = 1'b0;
            end
            default: ;
        endcase
    end

    assign pc = r_pc;

    // x0 is never written, so it reads zero without a read-side mux
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_pc <= '0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (w_we && w_rd != '0) r_regs[w_rd] <= w_wdata;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed cases plus random RV32I programs
// checked against a mnemonic-level architectural model.
module tb_cpu;
    typedef enum {
        LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        SB, SH, SW, LW, FENCE, ECALL, NOP0
    } mn_e;

    logic        clk;
    logic        n_rst;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] d;
    logic [31:0] address;
    logic        read_n_write;

    logic [31:0] m_x [32];
    logic [31:0] m_pc;
    int          n_chk;
    int          n_fail;

    cpu #(.WIDTH(32), .REG_BITS(5)) dut (
        .clk(clk), .n_rst(n_rst), .inst(inst), .pc(pc), .d(d),
        .address(address), .read_n_write(read_n_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input mn_e op, input logic [4:0] rd,
                                        input logic [4:0] rs1,
                                        input logic [4:0] rs2,
                                        input logic [31:0] imm);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = 3'd0;
        case (op)
            BNE, SLLI, SLL, SH:            f3 = 3'd1;
            SLTI, SLT, SW, LW:             f3 = 3'd2;
            SLTIU, SLTU:                   f3 = 3'd3;
            BLT, XORI, XOR:                f3 = 3'd4;
            BGE, SRLI, SRAI, SRL, SRA:     f3 = 3'd5;
            BLTU, ORI, OR:                 f3 = 3'd6;
            BGEU, ANDI, AND:               f3 = 3'd7;
            default:                       f3 = 3'd0;
        endcase
        f7 = (op inside {SUB, SRA, SRAI}) ? 7'h20 : 7'h00;
        case (op)
            LUI:   return {imm[19:0], rd, 7'h37};
            AUIPC: return {imm[19:0], rd, 7'h17};
            JAL:   return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
            JALR:  return {imm[11:0], rs1, f3, rd, 7'h67};
            BEQ, BNE, BLT, BGE, BLTU, BGEU:
                return {imm[12], imm[10:5], rs2, rs1, f3,
                        imm[4:1], imm[11], 7'h63};
            SLLI, SRLI, SRAI:
                return {f7, imm[4:0], rs1, f3, rd, 7'h13};
            ADDI, SLTI, SLTIU, XORI, ORI, ANDI:
                return {imm[11:0], rs1, f3, rd, 7'h13};
            ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND:
                return {f7, rs2, rs1, f3, rd, 7'h33};
            SB, SH, SW:
                return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
            LW:    return {imm[11:0], rs1, f3, rd, 7'h03};
            FENCE: return 32'h0ff0000f;
            ECALL: return 32'h00000073;
            default: return 32'h00000000;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 32'd0;
        foreach (m_x[i]) m_x[i] = 32'd0;
    endtask

    // Drive one instruction, check combinational outputs, retire in model
    task automatic exec(input mn_e op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
        logic [31:0] a, b, nx, val, ea, ed;
        logic        wr, er;
        a  = m_x[rs1];
        b  = m_x[rs2];
        nx = m_pc + 32'd4;
        val = 32'd0;
        er = 1'b1;
        ea = 32'd0;
        ed = 32'd0;
        wr = !(op inside {BEQ, BNE, BLT, BGE, BLTU, BGEU, SB, SH, SW,
                          LW, FENCE, ECALL, NOP0});
        case (op)
            LUI:   val = imm << 12;
            AUIPC: val = m_pc + (imm << 12);
            JAL:   begin val = m_pc + 32'd4; nx = m_pc + imm; end
            JALR:  begin val = m_pc + 32'd4; nx = (a + imm) & 32'hffff_fffe; end
            BEQ:   if (a == b) nx = m_pc + imm;
            BNE:   if (a != b) nx = m_pc + imm;
            BLT:   if ($signed(a) < $signed(b)) nx = m_pc + imm;
            BGE:   if ($signed(a) >= $signed(b)) nx = m_pc + imm;
            BLTU:  if (a < b) nx = m_pc + imm;
            BGEU:  if (a >= b) nx = m_pc + imm;
            ADDI:  val = a + imm;
            SLTI:  val = {31'd0, $signed(a) < $signed(imm)};
            SLTIU: val = {31'd0, a < imm};
            XORI:  val = a ^ imm;
            ORI:   val = a | imm;
            ANDI:  val = a & imm;
            SLLI:  val = a << imm[4:0];
            SRLI:  val = a >> imm[4:0];
            SRAI:  val = $signed(a) >>> imm[4:0];
            ADD:   val = a + b;
            SUB:   val = a - b;
            SLL:   val = a << b[4:0];
            SLT:   val = {31'd0, $signed(a) < $signed(b)};
            SLTU:  val = {31'd0, a < b};
            XOR:   val = a ^ b;
            SRL:   val = a >> b[4:0];
            SRA:   val = $signed(a) >>> b[4:0];
            OR:    val = a | b;
            AND:   val = a & b;
            SB, SH, SW: begin er = 1'b0; ea = a + imm; ed = b; end
            default: ;
        endcase
        inst = enc(op, rd, rs1, rs2, imm);
        #1;
        chk($sformatf("%s_pc", op.name()), pc, m_pc);
        chk($sformatf("%s_rnw", op.name()), {31'd0, read_n_write}, {31'd0, er});
        chk($sformatf("%s_addr", op.name()), address, ea);
        chk($sformatf("%s_d", op.name()), d, ed);
        @(posedge clk);
        m_pc = nx;
        if (wr && rd != 5'd0) m_x[rd] = val;
        @(negedge clk);
    endtask

    task automatic dump_regs();
        for (int i = 0; i < 32; i++) exec(SW, 5'd0, 5'd0, 5'(i), 32'd0);
    endtask

    // Asynchronous reset pulse placed in the low phase of the clock
    task automatic reset_pulse();
        #1 n_rst = 1'b0;
        #1 chk("pulse_pc", pc, 32'd0);
        model_reset();
        #1 n_rst = 1'b1;
    endtask

    function automatic logic [31:0] rnd_imm(input mn_e op);
        logic [31:0] r;
        r = $urandom;
        case (op)
            LUI, AUIPC:       return {12'd0, r[19:0]};
            JAL:              return {{11{r[20]}}, r[20:1], 1'b0};
            BEQ, BNE, BLT, BGE, BLTU, BGEU:
                              return {{19{r[12]}}, r[12:1], 1'b0};
            SLLI, SRLI, SRAI: return {27'd0, r[4:0]};
            default:          return {{20{r[11]}}, r[11:0]};
        endcase
    endfunction

    function automatic logic [4:0] rnd_reg();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        mn_e op;
        n_chk  = 0;
        n_fail = 0;
        n_rst  = 1'b0;
        inst   = 32'd0;
        model_reset();
        #3;
        chk("rst_pc", pc, 32'd0);
        inst = enc(SW, 5'd0, 5'd3, 5'd5, 32'h123);
        #1;
        chk("rst_store_rnw", {31'd0, read_n_write}, 32'd0);
        chk("rst_store_addr", address, 32'h123);
        chk("rst_store_d", d, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        exec(ADDI, 5'd1, 5'd0, 5'd0, 32'd7);
        exec(NOP0, 5'd0, 5'd0, 5'd0, 32'd0);
        reset_pulse();
        exec(NOP0, 5'd0, 5'd0, 5'd0, 32'd0);
        exec(SW, 5'd0, 5'd0, 5'd1, 32'd0);

        exec(LUI, 5'd31, 5'd0, 5'd0, 32'h0000f);
        exec(ADDI, 5'd31, 5'd31, 5'd0, 32'hffff_ffff);
        exec(SW, 5'd0, 5'd31, 5'd31, 32'hffff_faaa);
        exec(JAL, 5'd1, 5'd0, 5'd0, 32'd16);
        exec(SW, 5'd0, 5'd0, 5'd1, 32'd0);
        exec(SW, 5'd0, 5'd0, 5'd31, 32'd0);

        exec(ADDI, 5'd0, 5'd0, 5'd0, 32'd5);
        exec(ADD, 5'd2, 5'd0, 5'd0, 32'd0);
        exec(SW, 5'd0, 5'd0, 5'd2, 32'd0);
        exec(SW, 5'd0, 5'd0, 5'd0, 32'd0);
        reset_pulse();
        exec(NOP0, 5'd0, 5'd0, 5'd0, 32'd0);
        exec(FENCE, 5'd0, 5'd0, 5'd0, 32'd0);
        exec(BEQ, 5'd0, 5'd0, 5'd0, 32'hffff_fff8);
        exec(JALR, 5'd0, 5'd0, 5'd0, 32'hffff_fffd);
        exec(ECALL, 5'd0, 5'd0, 5'd0, 32'd0);
        exec(JALR, 5'd5, 5'd5, 5'd0, 32'd0);

        reset_pulse();
        for (int n = 0; n < 600; n++) begin
            op = mn_e'($urandom_range(0, int'(NOP0)));
            exec(op, rnd_reg(), rnd_reg(), rnd_reg(), rnd_imm(op));
            if (n % 150 == 149) dump_regs();
        end
        dump_regs();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data, register and address width.
REQ-002 SHALL have parameter REG_BITS, default 5, the register-index width (2**REG_BITS registers).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port n_rst, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 SHALL have port inst, input, 32 bits, the RV32I instruction at the current pc.
REQ-006 SHALL have port pc, output, WIDTH bits, the program counter register.
REQ-007 SHALL have port d, output, WIDTH bits, store data to memory.
REQ-008 SHALL have port address, output, WIDTH bits, the data memory address.
REQ-009 SHALL have port read_n_write, output, 1 bit; 0 = write (store) this cycle, 1 = read/idle.

Function
REQ-010 SHALL be a single-cycle core: decode/execute combinational from inst; pc and register-file writes commit on the rising clk edge.
REQ-011 SHALL contain 2**REG_BITS registers of WIDTH bits; x0 reads 0 always and ignores writes.
REQ-012 SHALL decode immediates per RV32I I/S/B/U/J formats, sign-extended to WIDTH.
REQ-013 SHALL execute LUI: rd = imm[31:12]<<12; pc += 4.
REQ-014 SHALL execute AUIPC: rd = pc + (imm<<12); pc += 4.
REQ-015 SHALL execute JAL: rd = pc+4; pc = pc + J-imm.
REQ-016 SHALL execute JALR: rd = pc+4; pc = (rs1 + I-imm) & ~1; rs1 is read before rd is written.
REQ-017 SHALL execute BEQ/BNE/BLT/BGE/BLTU/BGEU: pc = pc + B-imm if taken, else pc + 4.
REQ-018 SHALL execute OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI (shamt = imm[4:0]); pc += 4.
REQ-019 SHALL execute OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND (shift = rs2[4:0]); pc += 4.
REQ-020 SHALL execute STORE (SB/SH/SW): address = rs1 + S-imm, d = rs2, read_n_write = 0, combinationally during that cycle; pc += 4; no register write.
REQ-021 SHALL drive, for any non-store instruction: read_n_write = 1, address = 0, d = 0.
REQ-022 SHALL treat LOAD, FENCE, SYSTEM and unrecognised opcodes (including 0x00000000) as NOP: pc += 4, no register write, read_n_write = 1.
REQ-023 SHALL make all arithmetic modulo 2**WIDTH; pc wraps at 2**WIDTH, and no misalignment traps occur.
REQ-024 SHALL ensure no two writes to one register happen in a cycle; the ALU reads pre-edge register values.

Reset
REQ-025 SHALL, while n_rst = 0, immediately force pc = 0 and all registers to 0, independent of clk.
REQ-026 SHALL keep outputs decoded from inst during reset; read_n_write = 1 unless inst is a store.
REQ-027 SHALL execute the inst present at the first rising edge after n_rst rises, with pc = 0.

Verification
REQ-028 SHALL pass: pulse n_rst low mid-cycle with pc non-zero -> pc = 0 at once, registers 0; inst = 0x00000000 for one edge -> pc = 4, no register change.
REQ-029 SHALL pass: after reset, inst = 0x0000FFB7 (LUI x31,0xF) one edge -> x31 = 0x0000F000, pc advances 4.
REQ-030 SHALL pass: then inst = 0xFFFF8F93 (ADDI x31,x31,-1) one edge -> x31 = 0x0000EFFF, pc advances 4.
REQ-031 SHALL pass: then inst = 0xABFFA523 (SW x31,-0x556(x31)) -> before the edge address = 0x0000EAA9, d = 0x0000EFFF, read_n_write = 0; after the edge pc advances 4.
REQ-032 SHALL pass: then inst = 0x010000EF (JAL x1,+16) at pc = P -> x1 = P+4, pc = P+16, read_n_write = 1.
REQ-033 SHALL pass: ADDI x0,x0,5 then ADD x2,x0,x0 -> x2 = 0; BEQ x0,x0,-8 at pc = 8 -> pc = 0.
